disp_seven_seg_mux: RTL and testbench

Parametrised multiplexed seven-segment display driver. It scans DIGITS common-anode or common-cathode digits with a one-hot enable and decodes a 4-bit hex code per digit to segments. It adds per-digit decimal points, leading-zero blanking, per-digit blink and PWM brightness. It sits between the clock/time logic and the display pins.

---
 rtl/disp_seven_seg_mux.sv | 129 ++++++++++++
 tb/tb_disp_seven_seg_mux.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/disp_seven_seg_mux.sv
// Multiplexed seven-segment driver. Inputs are captured once per scan frame, and all outputs
// are decoded from that snapshot with leading-zero blanking, per-digit blink and PWM dimming.
module disp_seven_seg_mux #(
  parameter int unsigned DIGITS       = 4,
  parameter logic [19:0] SCAN_CNT     = 20'd49999,
  parameter int unsigned DIM_BITS     = 4,
  parameter logic [7:0]  BLINK_FRAMES = 8'd100
) (
  input  logic                  i_clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   i_code,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blink,
  input  logic                  i_lz_en,
  input  logic [DIM_BITS-1:0]   i_bright,
  output logic [DIGITS-1:0]     o_digit_en,
  output logic [6:0]            o_seg,
  output logic                  o_dp
);

  localparam int unsigned     IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [19:0]          r_cnt;
  logic [IdxW-1:0]      r_idx;
  logic [DIM_BITS-1:0]  r_pwm_cnt;
  logic [7:0]           r_frame_cnt;
  logic                 r_blink_ph;

  logic [4*DIGITS-1:0]  r_code;
  logic [DIGITS-1:0]    r_dp;
  logic [DIGITS-1:0]    r_blink;
  logic                 r_lz;
  logic [DIM_BITS-1:0]  r_bright;

  logic                 w_wrap;
  logic                 w_frame_end;
  logic [DIGITS-1:0]    w_lz_blank;
  logic                 w_zero_above;
  logic [3:0]           w_cur_code;
  logic [6:0]           w_glyph;
  logic                 w_blink_off;
  logic                 w_pwm_on;

  assign w_wrap      = (r_cnt == '0);
  assign w_frame_end = w_wrap && (r_idx == IdxLast);

  // Digit scan: the period reload also restarts the PWM ramp for the new digit.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= SCAN_CNT;
      r_idx     <= '0;
      r_pwm_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt     <= SCAN_CNT;
      r_idx     <= (r_idx == IdxLast) ? '0 : r_idx + IdxW'(1);
      r_pwm_cnt <= '0;
    end else begin
      r_cnt     <= r_cnt - 20'd1;
      r_pwm_cnt <= r_pwm_cnt + DIM_BITS'(1);
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_blink_ph  <= 1'b0;
      r_code      <= '0;
      r_dp        <= '0;
      r_blink     <= '0;
      r_lz        <= 1'b0;
      r_bright    <= '1;
    end else if (w_frame_end) begin
      r_code   <= i_code;
      r_dp     <= i_dp;
      r_blink  <= i_blink;
      r_lz     <= i_lz_en;
      r_bright <= i_bright;
      if (r_frame_cnt == BLINK_FRAMES - 8'd1) begin
        r_frame_cnt <= '0;
        r_blink_ph  <= ~r_blink_ph;
      end else begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // Walk down from the most significant digit; digit 0 is never blanked.
  always_comb begin
    w_lz_blank   = '0;
    w_zero_above = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      w_zero_above  = w_zero_above && (r_code[4*k +: 4] == 4'h0);
      w_lz_blank[k] = r_lz && w_zero_above;
    end
  end

  assign w_cur_code = r_code[4*r_idx +: 4];

  always_comb begin
    w_glyph = 7'h00;
    unique case (w_cur_code)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      4'hF: w_glyph = 7'h71;
    endcase
  end

  assign w_blink_off = r_blink_ph && r_blink[r_idx];
  assign w_pwm_on    = (&r_bright) || (r_pwm_cnt < r_bright);

  assign o_digit_en = w_pwm_on ? (DIGITS'(1) << r_idx) : '0;
  assign o_seg      = (w_blink_off || w_lz_blank[r_idx]) ? 7'h00 : w_glyph;
  assign o_dp       = !w_blink_off && r_dp[r_idx];

endmodule

// File: tb/tb_disp_seven_seg_mux.sv
// Bench for disp_seven_seg_mux: outputs compared every cycle against a model that derives
// digit, PWM phase and blink phase arithmetically from the cycle count since reset.
module tb_disp_seven_seg_mux;

  localparam int D     = 4;
  localparam int SC    = 7;
  localparam int DB    = 2;
  localparam int BF    = 2;
  localparam int P     = SC + 1;
  localparam int FRAME = P * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] code = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink = '0;
  logic        lz = 1'b0;
  logic [1:0]  bright = 2'b11;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic        dp_out;

  disp_seven_seg_mux #(
    .DIGITS      (D),
    .SCAN_CNT    (20'(SC)),
    .DIM_BITS    (DB),
    .BLINK_FRAMES(8'(BF))
  ) dut (
    .i_clk     (clk),
    .rst_n     (rst_n),
    .i_code    (code),
    .i_dp      (dp_in),
    .i_blink   (blink),
    .i_lz_en   (lz),
    .i_bright  (bright),
    .o_digit_en(digit_en),
    .o_seg     (seg),
    .o_dp      (dp_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: clocks since reset plus the inputs seen at each frame's last clock.
  int          t;
  logic [15:0] m_code;
  logic [3:0]  m_dp;
  logic [3:0]  m_blink;
  logic        m_lz;
  logic [1:0]  m_bright;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t        <= 0;
      m_code   <= '0;
      m_dp     <= '0;
      m_blink  <= '0;
      m_lz     <= 1'b0;
      m_bright <= 2'b11;
    end else begin
      t <= t + 1;
      if (t % FRAME == FRAME - 1) begin
        m_code   <= code;
        m_dp     <= dp_in;
        m_blink  <= blink;
        m_lz     <= lz;
        m_bright <= bright;
      end
    end
  end

  function automatic void expect_out(output logic [3:0] en, output logic [6:0] sg,
                                     output logic pt);
    int idx, pwm, frame;
    bit bph, off, lzb;
    idx   = (t / P) % D;
    pwm   = (t % P) % (1 << DB);
    frame = t / FRAME;
    bph   = ((frame / BF) % 2) == 1;
    en    = (m_bright == 2'b11 || pwm < int'(m_bright)) ? 4'(1 << idx) : 4'b0000;
    off   = bph && m_blink[idx];
    lzb   = m_lz && (idx >= 1) && ((m_code >> (4 * idx)) == 16'h0);
    sg    = (off || lzb) ? 7'h00 : glyph[m_code[4*idx +: 4]];
    pt    = !off && m_dp[idx];
  endfunction

  logic [3:0] e_en;
  logic [6:0] e_seg;
  logic       e_dp;

  always @(negedge clk) begin
    if (chk_en) begin
      expect_out(e_en, e_seg, e_dp);
      check_eq("digit_en", 32'(digit_en), 32'(e_en));
      check_eq("seg", 32'(seg), 32'(e_seg));
      check_eq("dp", 32'(dp_out), 32'(e_dp));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_en"}, 32'(digit_en), 32'h1);
    check_eq({tag, "_seg"}, 32'(seg), 32'h3F);
    check_eq({tag, "_dp"}, 32'(dp_out), 32'h0);
  endtask

  initial begin
    bit found;
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    run(FRAME * 2);

    // New code applied mid-frame must wait for the next frame boundary.
    run(FRAME / 2 + 3);
    code = 16'h1A90;
    run(FRAME * 3);

    code = 16'h0005; lz = 1'b1; dp_in = 4'b0100;
    run(FRAME * 3);

    bright = 2'd1; run(FRAME * 2);
    bright = 2'd0; run(FRAME * 2);
    bright = 2'd3; run(FRAME * 2);

    code = 16'h8888; lz = 1'b0; dp_in = 4'b0000; blink = 4'b0010;
    run(FRAME * 10);

    // Reset pulse while digit 2 is mid-period.
    found = 1'b0;
    for (int i = 0; i < FRAME * 2 && !found; i++) begin
      @(negedge clk);
      if ((t / P) % D == 2 && t % P == 3) found = 1'b1;
    end
    check_eq("wait_idx2", 32'(found), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    run(FRAME * 2);

    for (int i = 0; i < 200; i++) begin
      code   = 16'($urandom);
      if ($urandom_range(0, 2) == 0) code[15:8] = 8'h00;
      dp_in  = 4'($urandom);
      blink  = 4'($urandom);
      lz     = 1'($urandom);
      bright = 2'($urandom);
      run($urandom_range(1, 40));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
